usb_tx_bit_stuffer: RTL

Transmit-path stage directly upstream of the NRZI encoder. Accepts packet bytes over a valid/ready handshake and serializes them LSB-first, one bit per clk. Inserts a 0 after every run of STUFF_LIMIT consecutive 1s (USB bit stuffing). Drives the encoder's curr_bit and start_encoding inputs via bit_out and bit_valid.

---
 rtl/usb_tx_bit_stuffer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/usb_tx_bit_stuffer.sv
// usb_tx_bit_stuffer
//
// Transmit-path stage that sits directly upstream of the NRZI encoder.
// Packet bytes arrive over a valid/ready handshake. They are serialized
// LSB-first at one bit per clk. A 0 is inserted after every run of
// STUFF_LIMIT consecutive 1s (USB bit stuffing).
//
// Optional feature, enabled by defining USB_TX_SYNC_PREPEND_EN:
//   Each packet is prefixed with the SYNC pattern 0,0,0,0,0,0,0,1. The
//   final SYNC 1 counts toward the first stuffing run. With the macro
//   undefined, a packet starts directly with its data bits.
//
// Parameters:
//   STUFF_LIMIT  run of consecutive 1s that forces a stuffed 0 (2..15)
//   DATA_W       byte width on the input side
//
// Ports:
//   clk          system clock, one serial bit per rising edge
//   nRST         synchronous active-low reset
//   tx_valid     tx_data / tx_last are valid
//   tx_data      byte to send, transmitted LSB first
//   tx_last      marks the final byte of a packet
//   tx_ready     a byte can be accepted this cycle (hold register empty)
//   bit_out      serial bit to the NRZI encoder (curr_bit)
//   bit_valid    bit_out is meaningful (start_encoding)
//   stuff_pulse  the bit currently on bit_out is a stuffed 0
//   done         one-cycle pulse in the cycle after the final packet bit
//   underrun     one-cycle pulse in the cycle after the last bit of a
//                non-final byte when no follow-on byte was available
module usb_tx_bit_stuffer #(
    parameter int STUFF_LIMIT = 6,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              stuff_pulse,
    output logic              done,
    output logic              underrun
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CNT_W = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STUFF_LIMIT);

`ifdef USB_TX_SYNC_PREPEND_EN
    typedef enum logic [1:0] {IDLE, SYNC, DATA, STUFF} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, STUFF} state_t;
`endif

    state_t            state, state_n;
    logic [DATA_W-1:0] hold_data, hold_data_n;
    logic              hold_last, hold_last_n;
    logic              hold_full, hold_full_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic              shift_last, shift_last_n;
    logic [IDX_W-1:0]  bit_index, bit_index_n;
    logic [CNT_W-1:0]  ones_cnt, ones_cnt_n;
    // Set when a stuff bit is owed after the final bit of the current byte,
    // so STUFF knows to run the end-of-byte handling afterwards.
    logic              end_flag, end_flag_n;
    logic              done_pend, done_pend_n;
    logic              under_pend, under_pend_n;
    logic              bit_out_n, bit_valid_n, stuff_pulse_n;
`ifdef USB_TX_SYNC_PREPEND_EN
    logic [2:0]        sync_cnt, sync_cnt_n;
`endif

    logic              load, unload, finish_byte, byte_end;
    logic [CNT_W-1:0]  ones_next;

    assign tx_ready = ~hold_full;

    always_comb begin
        state_n       = state;
        hold_data_n   = hold_data;
        hold_last_n   = hold_last;
        shift_n       = shift;
        shift_last_n  = shift_last;
        bit_index_n   = bit_index;
        ones_cnt_n    = ones_cnt;
        end_flag_n    = end_flag;
        done_pend_n   = 1'b0;
        under_pend_n  = 1'b0;
        bit_out_n     = 1'b0;
        bit_valid_n   = 1'b0;
        stuff_pulse_n = 1'b0;
`ifdef USB_TX_SYNC_PREPEND_EN
        sync_cnt_n    = sync_cnt;
`endif
        load          = tx_valid && tx_ready;
        unload        = 1'b0;
        finish_byte   = 1'b0;
        byte_end      = (bit_index == LAST_IDX);
        ones_next     = shift[0] ? ones_cnt + CNT_W'(1) : '0;

        case (state)
            IDLE: begin
                if (hold_full) begin
                    shift_n      = hold_data;
                    shift_last_n = hold_last;
                    unload       = 1'b1;
                    bit_index_n  = '0;
                    ones_cnt_n   = '0;
                    end_flag_n   = 1'b0;
`ifdef USB_TX_SYNC_PREPEND_EN
                    sync_cnt_n   = '0;
                    state_n      = SYNC;
`else
                    state_n      = DATA;
`endif
                end
            end
`ifdef USB_TX_SYNC_PREPEND_EN
            SYNC: begin
                bit_valid_n = 1'b1;
                if (sync_cnt == 3'd7) begin
                    // The closing SYNC 1 opens the first run of ones.
                    bit_out_n  = 1'b1;
                    ones_cnt_n = CNT_W'(1);
                    state_n    = DATA;
                end else begin
                    sync_cnt_n = sync_cnt + 3'd1;
                end
            end
`endif
            DATA: begin
                bit_out_n   = shift[0];
                bit_valid_n = 1'b1;
                shift_n     = shift >> 1;
                bit_index_n = bit_index + IDX_W'(1);
                ones_cnt_n  = ones_next;
                if (ones_next == LIMIT) begin
                    // Stuff bit first; end-of-byte handling deferred to STUFF.
                    end_flag_n = byte_end;
                    state_n    = STUFF;
                end else if (byte_end) begin
                    finish_byte = 1'b1;
                end
            end
            STUFF: begin
                bit_valid_n   = 1'b1;
                stuff_pulse_n = 1'b1;
                ones_cnt_n    = '0;
                if (end_flag) begin
                    finish_byte = 1'b1;
                end else begin
                    state_n = DATA;
                end
            end
            default: state_n = IDLE;
        endcase

        if (finish_byte) begin
            end_flag_n = 1'b0;
            if (shift_last) begin
                done_pend_n = 1'b1;
                ones_cnt_n  = '0;
                state_n     = IDLE;
            end else if (hold_full) begin
                // Seamless reload: next byte's first bit follows next edge.
                shift_n      = hold_data;
                shift_last_n = hold_last;
                unload       = 1'b1;
                bit_index_n  = '0;
                state_n      = DATA;
            end else begin
                under_pend_n = 1'b1;
                ones_cnt_n   = '0;
                state_n      = IDLE;
            end
        end

        if (load) begin
            hold_data_n = tx_data;
            hold_last_n = tx_last;
        end
        hold_full_n = load | (hold_full & ~unload);
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state       <= IDLE;
            hold_data   <= '0;
            hold_last   <= 1'b0;
            hold_full   <= 1'b0;
            shift       <= '0;
            shift_last  <= 1'b0;
            bit_index   <= '0;
            ones_cnt    <= '0;
            end_flag    <= 1'b0;
            done_pend   <= 1'b0;
            under_pend  <= 1'b0;
            bit_out     <= 1'b0;
            bit_valid   <= 1'b0;
            stuff_pulse <= 1'b0;
            done        <= 1'b0;
            underrun    <= 1'b0;
`ifdef USB_TX_SYNC_PREPEND_EN
            sync_cnt    <= '0;
`endif
        end else begin
            state       <= state_n;
            hold_data   <= hold_data_n;
            hold_last   <= hold_last_n;
            hold_full   <= hold_full_n;
            shift       <= shift_n;
            shift_last  <= shift_last_n;
            bit_index   <= bit_index_n;
            ones_cnt    <= ones_cnt_n;
            end_flag    <= end_flag_n;
            done_pend   <= done_pend_n;
            under_pend  <= under_pend_n;
            bit_out     <= bit_out_n;
            bit_valid   <= bit_valid_n;
            stuff_pulse <= stuff_pulse_n;
            // Delayed one cycle so the pulse lands in the first idle cycle.
            done        <= done_pend;
            underrun    <= under_pend;
`ifdef USB_TX_SYNC_PREPEND_EN
            sync_cnt    <= sync_cnt_n;
`endif
        end
    end

endmodule
